// File: rtl/queue_ctrl_pkg.sv
// Shared definitions for the queue controller: slot state encoding and the
// width of every customer count presented to the display.
package queue_ctrl_pkg;

  localparam int unsigned CntW = 6;

  typedef enum logic [1:0] {
    SlotIdle = 2'd0,
    SlotBusy = 2'd1,
    SlotDone = 2'd2
  } slot_state_e;

endpackage

// File: rtl/queue_ctrl_slot.sv
// One service slot: IDLE -> BUSY (timed by enabled ticks) -> DONE (one cycle)
// -> IDLE.
module queue_ctrl_slot
  import queue_ctrl_pkg::*;
#(
  parameter int unsigned SrvTicks = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        tick_i,
  input  logic        en_i,
  output slot_state_e state_o,
  output logic        active_d_o
);

  slot_state_e     state_q, state_d;
  logic [CntW-1:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      SlotIdle: begin
        if (load_i) begin
          state_d = SlotBusy;
          timer_d = CntW'(SrvTicks);
        end
      end
      SlotBusy: begin
        if (tick_i && en_i) begin
          timer_d = timer_q - CntW'(1);
          if (timer_q == CntW'(1)) begin
            state_d = SlotDone;
          end
        end
      end
      SlotDone: state_d = SlotIdle;
      default:  state_d = SlotIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SlotIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign state_o    = state_q;
  // Lets the parent register u_cur so it tracks slot states without lag.
  assign active_d_o = (state_d != SlotIdle);

endmodule

// File: rtl/queue_ctrl.sv
// Multi-slot service queue controller: load arbiter, waiting-line counter and
// saturating completion totaliser around N_SLOT service slots.
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int unsigned N_SLOT    = 4,
  parameter int unsigned SRV_TICKS = 5,
  parameter int unsigned WAT_MAX   = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arrive,
  input  logic            tick,
  input  logic            en,
  output logic [CntW-1:0] u_tot,
  output logic [CntW-1:0] u_cur,
  output logic [CntW-1:0] u_wat,
  output logic            full,
  output logic            reject
);

  localparam logic [CntW-1:0] WatMax = CntW'(WAT_MAX);

  slot_state_e       state [N_SLOT];
  logic [N_SLOT-1:0] active_d;
  logic [N_SLOT-1:0] idle_sel;
  logic [N_SLOT-1:0] load;
  logic              idle_found;
  logic              do_load;

  logic [CntW-1:0] tot_q, tot_d, cur_q, cur_d, wat_q, wat_d;
  logic            full_q, full_d, reject_q, reject_d;
  logic [3:0]      n_done, n_active;
  logic [CntW:0]   tot_sum;

  for (genvar g = 0; g < N_SLOT; g++) begin : g_slot
    queue_ctrl_slot #(
      .SrvTicks(SRV_TICKS)
    ) u_slot (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (load[g]),
      .tick_i    (tick),
      .en_i      (en),
      .state_o   (state[g]),
      .active_d_o(active_d[g])
    );
  end

  // Lowest-index IDLE slot; a DONE slot is not yet loadable.
  always_comb begin
    idle_sel   = '0;
    idle_found = 1'b0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (!idle_found && state[i] == SlotIdle) begin
        idle_sel[i] = 1'b1;
        idle_found  = 1'b1;
      end
    end
  end

  always_comb begin
    wat_d    = wat_q;
    reject_d = 1'b0;
    do_load  = 1'b0;
    if (arrive) begin
      if (idle_found) begin
        do_load = 1'b1;
      end else if (wat_q < WatMax) begin
        wat_d = wat_q + CntW'(1);
      end else begin
        reject_d = 1'b1;
      end
    end else if (wat_q != '0 && idle_found) begin
      do_load = 1'b1;
      wat_d   = wat_q - CntW'(1);
    end
    load   = do_load ? idle_sel : '0;
    full_d = (wat_d == WatMax);
  end

  always_comb begin
    n_done   = '0;
    n_active = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      n_done   = n_done + 4'(state[i] == SlotDone);
      n_active = n_active + 4'(active_d[i]);
    end
    // Sum never exceeds 63 + 8, so the carry bit alone flags saturation.
    tot_sum = {1'b0, tot_q} + (CntW + 1)'(n_done);
    tot_d   = tot_sum[CntW] ? '1 : tot_sum[CntW-1:0];
    cur_d   = CntW'(n_active);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tot_q    <= '0;
      cur_q    <= '0;
      wat_q    <= '0;
      full_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      tot_q    <= tot_d;
      cur_q    <= cur_d;
      wat_q    <= wat_d;
      full_q   <= full_d;
      reject_q <= reject_d;
    end
  end

  assign u_tot  = tot_q;
  assign u_cur  = cur_q;
  assign u_wat  = wat_q;
  assign full   = full_q;
  assign reject = reject_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench for queue_ctrl: a customer-level reference model pushes the
// expected display outputs each cycle and a monitor compares them.
module tb_queue_ctrl;

  localparam int NS = 4;
  localparam int ST = 5;
  localparam int WM = 20;

  logic       clk = 1'b0;
  logic       rst, arrive, tick, en;
  logic [5:0] u_tot, u_cur, u_wat;
  logic       full, reject;

  always #5 clk = ~clk;

  queue_ctrl #(
    .N_SLOT   (NS),
    .SRV_TICKS(ST),
    .WAT_MAX  (WM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .arrive(arrive),
    .tick  (tick),
    .en    (en),
    .u_tot (u_tot),
    .u_cur (u_cur),
    .u_wat (u_wat),
    .full  (full),
    .reject(reject)
  );

  typedef struct packed {
    logic [5:0] tot;
    logic [5:0] cur;
    logic [5:0] wat;
    logic       full;
    logic       reject;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ncyc  = 0;

  // Reference model: ticks left per customer in service, and a flag for a
  // customer finishing this cycle (still occupying its slot).
  int left[NS];
  bit fin[NS];
  int m_tot = 0;
  int m_wat = 0;

  task automatic model_step(input bit a, input bit t, input bit e, input bit r);
    exp_t x;
    int   nd, idx, cur;
    bit   rej, ld;
    rej = 1'b0;
    if (r) begin
      for (int i = 0; i < NS; i++) begin
        left[i] = 0;
        fin[i]  = 1'b0;
      end
      m_tot = 0;
      m_wat = 0;
    end else begin
      nd  = 0;
      idx = -1;
      for (int i = 0; i < NS; i++) begin
        if (fin[i]) nd++;
        else if (left[i] == 0 && idx < 0) idx = i;
      end
      m_tot = (m_tot + nd > 63) ? 63 : m_tot + nd;
      for (int i = 0; i < NS; i++) begin
        if (fin[i]) fin[i] = 1'b0;
        else if (left[i] > 0 && t && e) begin
          left[i]--;
          if (left[i] == 0) fin[i] = 1'b1;
        end
      end
      ld = 1'b0;
      if (a) begin
        if (idx >= 0) ld = 1'b1;
        else if (m_wat < WM) m_wat++;
        else rej = 1'b1;
      end else if (m_wat > 0 && idx >= 0) begin
        ld = 1'b1;
        m_wat--;
      end
      if (ld) left[idx] = ST;
    end
    cur = 0;
    for (int i = 0; i < NS; i++) if (left[i] > 0 || fin[i]) cur++;
    x.tot    = 6'(m_tot);
    x.cur    = 6'(cur);
    x.wat    = 6'(m_wat);
    x.full   = (m_wat == WM);
    x.reject = rej;
    exp_q.push_back(x);
  endtask

  task automatic cycle(input bit a, input bit t, input bit e, input bit r);
    arrive = a;
    tick   = t;
    en     = e;
    rst    = r;
    @(posedge clk);
    model_step(a, t, e, r);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x, act;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      act = '{tot: u_tot, cur: u_cur, wat: u_wat, full: full, reject: reject};
      ncyc++;
      tests++;
      if (act !== x) begin
        fails++;
        $display("FAIL outputs cycle %0d: got tot=%0d cur=%0d wat=%0d full=%b rej=%b, want tot=%0d cur=%0d wat=%0d full=%b rej=%b",
                 ncyc, act.tot, act.cur, act.wat, act.full, act.reject,
                 x.tot, x.cur, x.wat, x.full, x.reject);
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    // single customer through a full service
    cycle(1, 0, 1, 0);
    repeat (ST) begin
      cycle(0, 1, 1, 0);
      cycle(0, 0, 1, 0);
    end
    repeat (3) cycle(0, 0, 1, 0);
    // six arrivals, no ticks: 4 in service, 2 waiting
    repeat (6) cycle(1, 0, 1, 0);
    // fill the waiting line, then overflow twice
    repeat (WM - 2) cycle(1, 0, 1, 0);
    repeat (2) cycle(1, 0, 1, 0);
    // ticks while frozen
    repeat (10) cycle(0, 1, 0, 0);
    // drain with enabled ticks, exercising DONE/gap/dispatch
    repeat (80) cycle(0, 1, 1, 0);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 199) == 0));
    end
    // saturation of the completion total with serial services
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 70; k++) begin
      cycle(1, 0, 1, 0);
      repeat (ST) cycle(0, 1, 1, 0);
      repeat (2) cycle(0, 0, 1, 0);
    end
    // reset mid-service beats a simultaneous arrival and tick
    cycle(1, 0, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(1, 1, 1, 1);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/queue_ctrl.md
QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 SHALL have parameter N_SLOT, default 4, number of parallel service slots (1..8).
REQ-002 SHALL have parameter SRV_TICKS, default 5, service duration in tick pulses (1..63).
REQ-003 SHALL have parameter WAT_MAX, default 20, waiting-line capacity (1..63).
REQ-004 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port arrive, input, 1, one-cycle arrival pulse.
REQ-007 SHALL have port tick, input, 1, one-cycle time-base pulse from the divider.
REQ-008 SHALL have port en, input, 1, run enable; 0 freezes service timers.
REQ-009 SHALL have port u_tot, output, 6, total customers completed, feeding display.
REQ-010 SHALL have port u_cur, output, 6, number of non-idle slots, feeding display.
REQ-011 SHALL have port u_wat, output, 6, number waiting, feeding display.
REQ-012 SHALL have port full, output, 1, high when u_wat == WAT_MAX.
REQ-013 SHALL have port reject, output, 1, one-cycle pulse on a dropped arrival.

Function
REQ-014 All outputs SHALL be registered; an event at edge k SHALL be visible after edge k.
REQ-015 Each slot SHALL run the states IDLE -> BUSY -> DONE -> IDLE.
REQ-016 A slot SHALL go from IDLE to BUSY on a load, with its timer set to SRV_TICKS.
REQ-017 In BUSY, each cycle with tick && en SHALL decrement the timer; reaching 0 SHALL move the slot to DONE.
REQ-018 DONE SHALL last exactly one cycle, SHALL increment u_tot, then return to IDLE.
REQ-019 At most one slot load SHALL occur per cycle, into the lowest-index IDLE slot.
REQ-020 Arrival with u_wat == 0 and an IDLE slot SHALL load the slot; u_wat stays 0.
REQ-021 Arrival with u_wat > 0 and an IDLE slot SHALL dispatch one waiting customer and enqueue the arrival; net u_wat unchanged.
REQ-022 Arrival with no IDLE slot and u_wat < WAT_MAX SHALL increment u_wat.
REQ-023 Arrival with no IDLE slot and u_wat == WAT_MAX SHALL pulse reject; all counts unchanged.
REQ-024 No arrival, u_wat > 0 and an IDLE slot SHALL dispatch one waiting customer (u_wat - 1).
REQ-025 A slot in DONE SHALL NOT count as IDLE; it becomes loadable the cycle after DONE.
REQ-026 u_cur SHALL equal the count of slots in BUSY or DONE; maximum N_SLOT.
REQ-027 u_tot SHALL saturate at 63.
REQ-028 Simultaneous DONE in several slots SHALL add the number of DONE slots to u_tot, saturating.
REQ-029 tick with en == 0 SHALL be ignored; arrivals and dispatch SHALL still operate.
REQ-030 reject SHALL be 0 in every cycle without a dropped arrival.

Reset
REQ-031 rst high at a clock edge SHALL force all slots to IDLE, all timers to 0, u_tot = u_cur = u_wat = 0, full = 0 and reject = 0.
REQ-032 rst SHALL take priority over arrive and tick in the same cycle; in-service customers are discarded and not counted.
REQ-033 The first arrival SHALL be accepted in the cycle after rst falls.

Structure
REQ-034 The slot state encoding and the 6-bit count width constant SHALL live in the shared header included by display.
REQ-035 One slot SHALL be a sub-module _queue_slot (FSM plus timer), instantiated N_SLOT times.
REQ-036 queue_ctrl SHALL contain the load arbiter, the waiting counter and the totaliser.

Verification
REQ-037 Reset, then one arrive, then 5 ticks with en = 1 -> u_cur = 1 from the next cycle; DONE after the 5th tick; u_tot = 1, u_cur = 0.
REQ-038 Send 6 arrivals with no ticks -> u_cur = 4, u_wat = 2, reject never asserted.
REQ-039 Fill to u_cur = 4, u_wat = 20; send 1 more arrival -> full = 1, reject pulses 1 cycle, counts unchanged.
REQ-040 With u_wat = 3, finish one slot -> DONE cycle, then a 1-cycle gap, then a dispatch; u_wat = 2, u_cur back to 4.
REQ-041 Drive en = 0 with 10 ticks while slots are BUSY -> timers and u_tot unchanged.
REQ-042 Drive 70 serial services -> u_tot holds 63; assert rst mid-service -> all outputs 0 next cycle.
